// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared request type and sizing helpers for mem_port_arbiter.
// Optional forwarding of same-cycle store data is enabled by MEM_ARB_FWD_EN.
package mem_arb_pkg;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;
  localparam int DEF_LANES  = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LANE_IDX_W = idx_w(DEF_LANES);

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester at or after ptr.
// Pointer state is owned by the instantiating block.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        gnt[j]   = 1'b1;
        gnt_idx  = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one load + one store per cycle onto main_memory ports.
// Define MEM_ARB_FWD_EN to forward same-cycle store data to a matching load.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_LANES-1:0]        req_valid,
  input  logic [NUM_LANES-1:0]        req_we,
  input  logic [NUM_LANES*ADDR_W-1:0] req_addr,
  input  logic [NUM_LANES*DATA_W-1:0] req_wdata,
  output logic [NUM_LANES-1:0]        req_ready,
  output logic [NUM_LANES-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [ADDR_W-1:0]           mem_wr_addr,
  output logic [DATA_W-1:0]           mem_wr_data,
  output logic                        mem_wr_en,
  output logic [ADDR_W-1:0]           mem_rd_addr,
  input  logic [DATA_W-1:0]           mem_data_out
);

  localparam int IW = idx_w(NUM_LANES);

  mem_req_t             req [NUM_LANES];
  logic [NUM_LANES-1:0] ld_req, st_req;
  logic [NUM_LANES-1:0] ld_gnt, st_gnt;
  logic [IW-1:0]        ld_idx, st_idx;
  logic                 ld_any, st_any;

  logic [IW-1:0]        rd_ptr, wr_ptr;
  logic                 rsp_pend;
  logic [IW-1:0]        rsp_lane;

  // Widths are fitted to the package request type at the lane boundary.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      req[i].we    = req_we[i];
      req[i].addr  = REQ_ADDR_W'(req_addr[i*ADDR_W +: ADDR_W]);
      req[i].wdata = REQ_DATA_W'(req_wdata[i*DATA_W +: DATA_W]);
      ld_req[i]    = req_valid[i] & ~req[i].we;
      st_req[i]    = req_valid[i] &  req[i].we;
    end
  end

  rr_arbiter #(.N(NUM_LANES), .IW(IW)) u_ld_arb (
    .req     (ld_req),
    .ptr     (rd_ptr),
    .gnt     (ld_gnt),
    .gnt_idx (ld_idx),
    .any     (ld_any)
  );

  rr_arbiter #(.N(NUM_LANES), .IW(IW)) u_st_arb (
    .req     (st_req),
    .ptr     (wr_ptr),
    .gnt     (st_gnt),
    .gnt_idx (st_idx),
    .any     (st_any)
  );

  assign req_ready   = ld_gnt | st_gnt;
  assign mem_wr_en   = st_any;
  assign mem_wr_addr = ADDR_W'(req[st_idx].addr);
  assign mem_wr_data = DATA_W'(req[st_idx].wdata);
  assign mem_rd_addr = ld_any ? ADDR_W'(req[ld_idx].addr)
                              : ADDR_W'(req[0].addr);

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] g);
    return (int'(g) == NUM_LANES - 1) ? '0 : g + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      rsp_pend <= 1'b0;
      rsp_lane <= '0;
    end else begin
      if (ld_any) rd_ptr <= ptr_after(ld_idx);
      if (st_any) wr_ptr <= ptr_after(st_idx);
      rsp_pend <= ld_any;
      rsp_lane <= ld_idx;
    end
  end

  always_comb begin
    rsp_valid           = '0;
    rsp_valid[rsp_lane] = rsp_pend;
  end

`ifdef MEM_ARB_FWD_EN
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              fwd_match;

  assign fwd_match = ld_any && st_any &&
                     (req[ld_idx].addr == req[st_idx].addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      fwd_hit  <= fwd_match;
      fwd_data <= mem_wr_data;
    end
  end

  assign rsp_rdata = fwd_hit ? fwd_data : mem_data_out;
`else
  // Memory reads old contents on a same-address collision.
  assign rsp_rdata = mem_data_out;
`endif

endmodule
